// File: rtl/control_pipeline_unit.sv
// Carries the decoded control bundle from ID through the ID/EX, EX/MEM and MEM/WB
// control registers, detects load-use hazards and keeps a saturating stall count.
module control_pipeline_unit #(
  parameter int REG_ADDR_SZ  = 5,
  parameter int ALU_OP_SZ    = 3,
  parameter int STALL_CNT_SZ = 16,
  parameter int JAL_REG      = 31
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic                    i_flush_D,
  input  logic [ALU_OP_SZ-1:0]    i_alu_op_MC,
  input  logic                    i_reg_dst_MC,
  input  logic                    i_jal_sel_MC,
  input  logic                    i_alu_src_MC,
  input  logic                    i_mem_read_MC,
  input  logic                    i_mem_write_MC,
  input  logic                    i_reg_write_MC,
  input  logic                    i_bds_sel_MC,
  input  logic                    i_mem_to_reg_MC,
  input  logic [REG_ADDR_SZ-1:0]  i_rs_D,
  input  logic [REG_ADDR_SZ-1:0]  i_rt_D,
  input  logic [REG_ADDR_SZ-1:0]  i_rd_D,
  output logic                    o_stall_D,
  output logic [ALU_OP_SZ-1:0]    o_alu_op_E,
  output logic                    o_alu_src_E,
  output logic [REG_ADDR_SZ-1:0]  o_write_reg_E,
  output logic [REG_ADDR_SZ-1:0]  o_write_reg_M,
  output logic [REG_ADDR_SZ-1:0]  o_write_reg_W,
  output logic                    o_reg_write_E,
  output logic                    o_reg_write_M,
  output logic                    o_reg_write_W,
  output logic                    o_mem_read_E,
  output logic                    o_mem_read_M,
  output logic                    o_mem_write_M,
  output logic                    o_mem_to_reg_W,
  output logic                    o_bds_sel_W,
  output logic [STALL_CNT_SZ-1:0] o_stall_count
);

  typedef struct packed {
    logic [ALU_OP_SZ-1:0]   alu_op;
    logic                   alu_src;
    logic                   mem_read;
    logic                   mem_write;
    logic                   reg_write;
    logic                   mem_to_reg;
    logic                   bds_sel;
    logic [REG_ADDR_SZ-1:0] write_reg;
  } ex_ctl_t;

  typedef struct packed {
    logic                   mem_read;
    logic                   mem_write;
    logic                   reg_write;
    logic                   mem_to_reg;
    logic                   bds_sel;
    logic [REG_ADDR_SZ-1:0] write_reg;
  } mem_ctl_t;

  typedef struct packed {
    logic                   reg_write;
    logic                   mem_to_reg;
    logic                   bds_sel;
    logic [REG_ADDR_SZ-1:0] write_reg;
  } wb_ctl_t;

  ex_ctl_t                 ex_q, ex_d;
  mem_ctl_t                mem_q, mem_d;
  wb_ctl_t                 wb_q, wb_d;
  logic [REG_ADDR_SZ-1:0]  write_reg_D;
  logic                    stall;
  logic [STALL_CNT_SZ-1:0] stall_cnt_q;

  // A JAL always links into JAL_REG, overriding the rd/rt choice.
  always_comb begin
    write_reg_D = i_reg_dst_MC ? i_rd_D : i_rt_D;
    if (i_jal_sel_MC) write_reg_D = REG_ADDR_SZ'(JAL_REG);
  end

  // Load in EX whose target feeds the instruction in ID; register 0 never hazards.
  always_comb begin
    stall = ex_q.mem_read && (ex_q.write_reg != '0) &&
            ((ex_q.write_reg == i_rs_D) || (ex_q.write_reg == i_rt_D));
  end

  always_comb begin
    ex_d = '0;
    if (!(stall || i_flush_D)) begin
      ex_d.alu_op     = i_alu_op_MC;
      ex_d.alu_src    = i_alu_src_MC;
      ex_d.mem_read   = i_mem_read_MC;
      ex_d.mem_write  = i_mem_write_MC;
      ex_d.reg_write  = i_reg_write_MC;
      ex_d.mem_to_reg = i_mem_to_reg_MC;
      ex_d.bds_sel    = i_bds_sel_MC;
      ex_d.write_reg  = write_reg_D;
    end
    mem_d.mem_read   = ex_q.mem_read;
    mem_d.mem_write  = ex_q.mem_write;
    mem_d.reg_write  = ex_q.reg_write;
    mem_d.mem_to_reg = ex_q.mem_to_reg;
    mem_d.bds_sel    = ex_q.bds_sel;
    mem_d.write_reg  = ex_q.write_reg;
    wb_d.reg_write   = mem_q.reg_write;
    wb_d.mem_to_reg  = mem_q.mem_to_reg;
    wb_d.bds_sel     = mem_q.bds_sel;
    wb_d.write_reg   = mem_q.write_reg;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else if (i_enable) begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign o_stall_D      = stall;
  assign o_alu_op_E     = ex_q.alu_op;
  assign o_alu_src_E    = ex_q.alu_src;
  assign o_write_reg_E  = ex_q.write_reg;
  assign o_reg_write_E  = ex_q.reg_write;
  assign o_mem_read_E   = ex_q.mem_read;
  assign o_write_reg_M  = mem_q.write_reg;
  assign o_reg_write_M  = mem_q.reg_write;
  assign o_mem_read_M   = mem_q.mem_read;
  assign o_mem_write_M  = mem_q.mem_write;
  assign o_write_reg_W  = wb_q.write_reg;
  assign o_reg_write_W  = wb_q.reg_write;
  assign o_mem_to_reg_W = wb_q.mem_to_reg;
  assign o_bds_sel_W    = wb_q.bds_sel;
  assign o_stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_control_pipeline_unit.sv
// Bench for control_pipeline_unit: directed scenarios plus randomized traffic
// checked against a stage-array pipeline model.
module tb_control_pipeline_unit;

  typedef struct packed {
    logic       reg_dst, jal_sel, alu_src, mem_read, mem_write, reg_write, bds_sel, mem_to_reg;
    logic [2:0] alu_op;
    logic [4:0] rs, rt, rd;
  } id_t;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src, mem_read, mem_write, reg_write, mem_to_reg, bds_sel;
    logic [4:0] wr;
  } stage_t;

  // clock / reset
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  logic enable = 1'b1;
  logic flush = 1'b0;
  id_t  cur = '0;

  logic       o_stall_D, o_alu_src_E, o_reg_write_E, o_reg_write_M, o_reg_write_W;
  logic       o_mem_read_E, o_mem_read_M, o_mem_write_M, o_mem_to_reg_W, o_bds_sel_W;
  logic [2:0] o_alu_op_E;
  logic [4:0] o_write_reg_E, o_write_reg_M, o_write_reg_W;
  logic [15:0] o_stall_count;

  logic       s_stall_D, s_alu_src_E, s_reg_write_E, s_reg_write_M, s_reg_write_W;
  logic       s_mem_read_E, s_mem_read_M, s_mem_write_M, s_mem_to_reg_W, s_bds_sel_W;
  logic [2:0] s_alu_op_E;
  logic [4:0] s_write_reg_E, s_write_reg_M, s_write_reg_W;
  logic [1:0] s_stall_count;

  control_pipeline_unit dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(enable), .i_flush_D(flush),
    .i_alu_op_MC(cur.alu_op), .i_reg_dst_MC(cur.reg_dst), .i_jal_sel_MC(cur.jal_sel),
    .i_alu_src_MC(cur.alu_src), .i_mem_read_MC(cur.mem_read), .i_mem_write_MC(cur.mem_write),
    .i_reg_write_MC(cur.reg_write), .i_bds_sel_MC(cur.bds_sel), .i_mem_to_reg_MC(cur.mem_to_reg),
    .i_rs_D(cur.rs), .i_rt_D(cur.rt), .i_rd_D(cur.rd),
    .o_stall_D(o_stall_D), .o_alu_op_E(o_alu_op_E), .o_alu_src_E(o_alu_src_E),
    .o_write_reg_E(o_write_reg_E), .o_write_reg_M(o_write_reg_M), .o_write_reg_W(o_write_reg_W),
    .o_reg_write_E(o_reg_write_E), .o_reg_write_M(o_reg_write_M), .o_reg_write_W(o_reg_write_W),
    .o_mem_read_E(o_mem_read_E), .o_mem_read_M(o_mem_read_M), .o_mem_write_M(o_mem_write_M),
    .o_mem_to_reg_W(o_mem_to_reg_W), .o_bds_sel_W(o_bds_sel_W), .o_stall_count(o_stall_count)
  );

  control_pipeline_unit #(.STALL_CNT_SZ(2)) small_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(enable), .i_flush_D(flush),
    .i_alu_op_MC(cur.alu_op), .i_reg_dst_MC(cur.reg_dst), .i_jal_sel_MC(cur.jal_sel),
    .i_alu_src_MC(cur.alu_src), .i_mem_read_MC(cur.mem_read), .i_mem_write_MC(cur.mem_write),
    .i_reg_write_MC(cur.reg_write), .i_bds_sel_MC(cur.bds_sel), .i_mem_to_reg_MC(cur.mem_to_reg),
    .i_rs_D(cur.rs), .i_rt_D(cur.rt), .i_rd_D(cur.rd),
    .o_stall_D(s_stall_D), .o_alu_op_E(s_alu_op_E), .o_alu_src_E(s_alu_src_E),
    .o_write_reg_E(s_write_reg_E), .o_write_reg_M(s_write_reg_M), .o_write_reg_W(s_write_reg_W),
    .o_reg_write_E(s_reg_write_E), .o_reg_write_M(s_reg_write_M), .o_reg_write_W(s_reg_write_W),
    .o_mem_read_E(s_mem_read_E), .o_mem_read_M(s_mem_read_M), .o_mem_write_M(s_mem_write_M),
    .o_mem_to_reg_W(s_mem_to_reg_W), .o_bds_sel_W(s_bds_sel_W), .o_stall_count(s_stall_count)
  );

  // reference model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB; total stall cycles unbounded
  stage_t      pipe [3];
  int unsigned stalls;
  int          n_pass = 0;
  int          n_total = 0;

  function automatic logic model_stall();
    return pipe[0].mem_read && (pipe[0].wr != 5'd0) &&
           ((pipe[0].wr == cur.rs) || (pipe[0].wr == cur.rt));
  endfunction

  function automatic stage_t decode(id_t x);
    stage_t s;
    s.alu_op = x.alu_op;       s.alu_src = x.alu_src;
    s.mem_read = x.mem_read;   s.mem_write = x.mem_write;
    s.reg_write = x.reg_write; s.mem_to_reg = x.mem_to_reg;
    s.bds_sel = x.bds_sel;
    s.wr = x.jal_sel ? 5'd31 : (x.reg_dst ? x.rd : x.rt);
    return s;
  endfunction

  function automatic logic [15:0] exp_cnt16();
    return (stalls > 32'd65535) ? 16'hFFFF : 16'(stalls);
  endfunction

  function automatic logic [1:0] exp_cnt2();
    return (stalls > 32'd3) ? 2'd3 : 2'(stalls);
  endfunction

  // driver tasks
  task automatic tick();
    logic st;
    st = model_stall();
    if (enable) begin
      if (st) stalls++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (st || flush) ? stage_t'('0) : decode(cur);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    cur = '0; flush = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    stalls = 0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    #1;
  endtask

  function automatic id_t load_op(logic [4:0] rt);
    id_t x = '0;
    x.mem_read = 1'b1; x.mem_to_reg = 1'b1; x.reg_write = 1'b1; x.alu_src = 1'b1; x.rt = rt;
    return x;
  endfunction

  function automatic id_t rtype_op(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    id_t x = '0;
    x.reg_dst = 1'b1; x.reg_write = 1'b1; x.alu_op = 3'b010; x.rs = rs; x.rt = rt; x.rd = rd;
    return x;
  endfunction

  task automatic test_reset();
    i_rst_n = 1'b0;
    cur = rtype_op(5'd1, 5'd2, 5'd3);
    #3;
    n_total++; if ({o_stall_D, o_alu_op_E, o_alu_src_E, o_write_reg_E, o_reg_write_E, o_mem_read_E} !== 13'd0)
      $display("FAIL reset_e got %h want 0", {o_stall_D, o_alu_op_E, o_alu_src_E, o_write_reg_E, o_reg_write_E, o_mem_read_E}); else n_pass++;
    n_total++; if ({o_write_reg_M, o_reg_write_M, o_mem_read_M, o_mem_write_M} !== 8'd0)
      $display("FAIL reset_m got %h want 0", {o_write_reg_M, o_reg_write_M, o_mem_read_M, o_mem_write_M}); else n_pass++;
    n_total++; if ({o_write_reg_W, o_reg_write_W, o_mem_to_reg_W, o_bds_sel_W, o_stall_count} !== 24'd0)
      $display("FAIL reset_w_cnt got %h want 0", {o_write_reg_W, o_reg_write_W, o_mem_to_reg_W, o_bds_sel_W, o_stall_count}); else n_pass++;
    do_reset();
  endtask

  task automatic test_rtype();
    do_reset();
    cur = rtype_op(5'd1, 5'd2, 5'd7);
    tick();
    n_total++; if (o_write_reg_E !== 5'd7) $display("FAIL rtype_wr_e got %0d want 7", o_write_reg_E); else n_pass++;
    n_total++; if (o_alu_op_E !== 3'b010) $display("FAIL rtype_aluop_e got %b want 010", o_alu_op_E); else n_pass++;
    cur = '0;
    tick();
    n_total++; if (o_write_reg_M !== 5'd7) $display("FAIL rtype_wr_m got %0d want 7", o_write_reg_M); else n_pass++;
    tick();
    n_total++; if ({o_reg_write_W, o_write_reg_W} !== {1'b1, 5'd7})
      $display("FAIL rtype_w got rw=%b wr=%0d want rw=1 wr=7", o_reg_write_W, o_write_reg_W); else n_pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    cur = load_op(5'd5);
    tick();
    cur = rtype_op(5'd5, 5'd0, 5'd9);
    #1;
    n_total++; if (o_stall_D !== 1'b1) $display("FAIL lu_stall got %b want 1", o_stall_D); else n_pass++;
    tick();
    n_total++; if (o_reg_write_E !== 1'b0) $display("FAIL lu_bubble_rw_e got %b want 0", o_reg_write_E); else n_pass++;
    n_total++; if (o_stall_D !== 1'b0) $display("FAIL lu_stall_once got %b want 0", o_stall_D); else n_pass++;
    n_total++; if (o_stall_count !== 16'd1) $display("FAIL lu_count got %0d want 1", o_stall_count); else n_pass++;
    tick();
    n_total++; if ({o_mem_to_reg_W, o_write_reg_W} !== {1'b1, 5'd5})
      $display("FAIL lu_w got m2r=%b wr=%0d want m2r=1 wr=5", o_mem_to_reg_W, o_write_reg_W); else n_pass++;
    n_total++; if ({o_reg_write_E, o_write_reg_E} !== {1'b1, 5'd9})
      $display("FAIL lu_resume_e got rw=%b wr=%0d want rw=1 wr=9", o_reg_write_E, o_write_reg_E); else n_pass++;
  endtask

  task automatic test_reg0();
    do_reset();
    cur = load_op(5'd0);
    tick();
    cur = rtype_op(5'd0, 5'd0, 5'd4);
    #1;
    n_total++; if (o_mem_read_E !== 1'b1) $display("FAIL r0_load_e got %b want 1", o_mem_read_E); else n_pass++;
    n_total++; if (o_stall_D !== 1'b0) $display("FAIL r0_no_stall got %b want 0", o_stall_D); else n_pass++;
  endtask

  task automatic test_jal();
    do_reset();
    cur = '0;
    cur.jal_sel = 1'b1; cur.bds_sel = 1'b1; cur.reg_write = 1'b1; cur.reg_dst = 1'b1; cur.rd = 5'd3;
    tick();
    cur = '0;
    tick();
    tick();
    n_total++; if ({o_write_reg_W, o_bds_sel_W, o_reg_write_W} !== {5'd31, 1'b1, 1'b1})
      $display("FAIL jal_w got wr=%0d bds=%b rw=%b want 31 1 1", o_write_reg_W, o_bds_sel_W, o_reg_write_W); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    cur = '0; cur.mem_write = 1'b1; cur.alu_src = 1'b1; cur.rt = 5'd4;
    flush = 1'b1;
    tick();
    flush = 1'b0; cur = '0;
    tick();
    n_total++; if (o_mem_write_M !== 1'b0) $display("FAIL flush_store_m got %b want 0", o_mem_write_M); else n_pass++;
    // stall and flush in the same cycle
    do_reset();
    cur = load_op(5'd6);
    tick();
    cur = rtype_op(5'd6, 5'd1, 5'd2);
    flush = 1'b1;
    tick();
    n_total++; if ({o_reg_write_E, o_write_reg_E, o_stall_count} !== 22'd1)
      $display("FAIL fs_bubble got rw=%b wr=%0d cnt=%0d want 0 0 1", o_reg_write_E, o_write_reg_E, o_stall_count); else n_pass++;
    flush = 1'b0;
    cur = rtype_op(5'd1, 5'd2, 5'd8);
    tick();
    n_total++; if ({o_reg_write_E, o_write_reg_E, o_write_reg_M, o_write_reg_W} !== {1'b1, 5'd8, 5'd0, 5'd6})
      $display("FAIL fs_single got e=%0d m=%0d w=%0d want 8 0 6", o_write_reg_E, o_write_reg_M, o_write_reg_W); else n_pass++;
  endtask

  task automatic test_enable_hold();
    do_reset();
    cur = rtype_op(5'd1, 5'd2, 5'd7);
    tick();
    cur = load_op(5'd5);
    tick();
    cur = rtype_op(5'd5, 5'd3, 5'd9);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++; if ({o_stall_D, o_mem_read_E, o_write_reg_E, o_write_reg_M, o_write_reg_W, o_stall_count} !== {1'b1, 1'b1, 5'd5, 5'd7, 5'd0, 16'd0})
        $display("FAIL hold_%0d got st=%b e=%0d m=%0d w=%0d cnt=%0d", i, o_stall_D, o_write_reg_E, o_write_reg_M, o_write_reg_W, o_stall_count); else n_pass++;
    end
    enable = 1'b1;
    tick();
    n_total++; if ({o_stall_count, o_write_reg_E, o_write_reg_M, o_write_reg_W} !== {16'd1, 5'd0, 5'd5, 5'd7})
      $display("FAIL hold_resume got cnt=%0d e=%0d m=%0d w=%0d want 1 0 5 7", o_stall_count, o_write_reg_E, o_write_reg_M, o_write_reg_W); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    cur = load_op(5'd5);
    tick();
    cur = rtype_op(5'd5, 5'd0, 5'd1);
    tick();
    cur = load_op(5'd3);
    tick();
    cur = rtype_op(5'd3, 5'd0, 5'd2);
    #1;
    n_total++; if ({o_stall_D, o_stall_count} !== {1'b1, 16'd1})
      $display("FAIL ar_pre got st=%b cnt=%0d want 1 1", o_stall_D, o_stall_count); else n_pass++;
    #1;
    i_rst_n = 1'b0;
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    stalls = 0;
    #1;
    n_total++; if ({o_stall_D, o_stall_count, o_write_reg_E, o_mem_read_E, o_write_reg_M, o_write_reg_W, o_reg_write_W} !== 34'd0)
      $display("FAIL ar_now got st=%b cnt=%0d e=%0d m=%0d w=%0d", o_stall_D, o_stall_count, o_write_reg_E, o_write_reg_M, o_write_reg_W); else n_pass++;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    cur = '0;
    tick();
    n_total++; if ({o_stall_count, o_write_reg_E, o_write_reg_M, o_mem_to_reg_W} !== 27'd0)
      $display("FAIL ar_release got cnt=%0d e=%0d m=%0d", o_stall_count, o_write_reg_E, o_write_reg_M); else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cur = load_op(5'd5);
      tick();
      cur = rtype_op(5'd5, 5'd0, 5'd1);
      tick();
    end
    n_total++; if (s_stall_count !== 2'd3) $display("FAIL sat_small got %0d want 3", s_stall_count); else n_pass++;
    n_total++; if (o_stall_count !== 16'd5) $display("FAIL sat_wide got %0d want 5", o_stall_count); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cur.reg_dst = 1'($urandom_range(0, 1));
      cur.jal_sel = ($urandom_range(0, 7) == 0);
      cur.alu_src = 1'($urandom_range(0, 1));
      cur.mem_read = ($urandom_range(0, 2) == 0);
      cur.mem_write = 1'($urandom_range(0, 1));
      cur.reg_write = 1'($urandom_range(0, 1));
      cur.bds_sel = 1'($urandom_range(0, 1));
      cur.mem_to_reg = 1'($urandom_range(0, 1));
      cur.alu_op = 3'($urandom_range(0, 7));
      cur.rs = 5'($urandom_range(0, 3));
      cur.rt = 5'($urandom_range(0, 3));
      cur.rd = 5'($urandom_range(0, 31));
      flush = ($urandom_range(0, 7) == 0);
      enable = ($urandom_range(0, 7) != 0);
      #1;
      n_total++; if (o_stall_D !== model_stall())
        $display("FAIL rnd_stall[%0d] got %b want %b", i, o_stall_D, model_stall()); else n_pass++;
      tick();
      n_total++; if ({o_alu_op_E, o_alu_src_E, o_mem_read_E, o_reg_write_E, o_write_reg_E} !==
                     {pipe[0].alu_op, pipe[0].alu_src, pipe[0].mem_read, pipe[0].reg_write, pipe[0].wr})
        $display("FAIL rnd_e[%0d] got %h want %h", i, {o_alu_op_E, o_alu_src_E, o_mem_read_E, o_reg_write_E, o_write_reg_E},
                 {pipe[0].alu_op, pipe[0].alu_src, pipe[0].mem_read, pipe[0].reg_write, pipe[0].wr}); else n_pass++;
      n_total++; if ({o_mem_read_M, o_mem_write_M, o_reg_write_M, o_write_reg_M} !==
                     {pipe[1].mem_read, pipe[1].mem_write, pipe[1].reg_write, pipe[1].wr})
        $display("FAIL rnd_m[%0d] got %h want %h", i, {o_mem_read_M, o_mem_write_M, o_reg_write_M, o_write_reg_M},
                 {pipe[1].mem_read, pipe[1].mem_write, pipe[1].reg_write, pipe[1].wr}); else n_pass++;
      n_total++; if ({o_reg_write_W, o_mem_to_reg_W, o_bds_sel_W, o_write_reg_W} !==
                     {pipe[2].reg_write, pipe[2].mem_to_reg, pipe[2].bds_sel, pipe[2].wr})
        $display("FAIL rnd_w[%0d] got %h want %h", i, {o_reg_write_W, o_mem_to_reg_W, o_bds_sel_W, o_write_reg_W},
                 {pipe[2].reg_write, pipe[2].mem_to_reg, pipe[2].bds_sel, pipe[2].wr}); else n_pass++;
      n_total++; if ({o_stall_count, s_stall_count} !== {exp_cnt16(), exp_cnt2()})
        $display("FAIL rnd_cnt[%0d] got %0d/%0d want %0d/%0d", i, o_stall_count, s_stall_count, exp_cnt16(), exp_cnt2()); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_use();
    test_reg0();
    test_jal();
    test_flush();
    test_enable_hold();
    test_async_reset();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
